alu_issue: RTL
==============

// Module: alu_issue
// PURPOSE
//  Producer end of the ALU interface: decodes ALUOp class + funct3/funct7[5] into the 4-bit AluOp
//  code and selects operands A/B, registering them toward the ALU.
//  Sits between decode/regfile read and the ALU.
//  Two-entry skid buffer with valid/ready on both sides, so a stalled ALU/EX stage never drops an op.
// PARAMETERS
//  XLEN     32  operand width
// PORTS
//  clk           in   1     clock; all state updates on posedge
//  rst           in   1     synchronous, active-high reset
//  flush         in   1     synchronous discard of all buffered ops (branch redirect)
//  in_valid      in   1     upstream op valid
//  in_ready      out  1     buffer can accept an op this cycle
//  alu_op_class  in   2     00 load/store, 01 branch, 10 R-type, 11 I-type ALU
//  funct3        in   3     instruction funct3
//  funct7_b5     in   1     instruction bit 30
//  alu_src       in   1     1: B = imm, 0: B = rs2_data
//  rs1_data      in   XLEN  operand A source
//  rs2_data      in   XLEN  register operand B source
//  imm           in   XLEN  sign-extended immediate
//  out_valid     out  1     AluOp/A/B valid toward ALU
//  out_ready     in   1     ALU/EX stage consumes the op this cycle
//  AluOp         out  4     ALU operation code
//  A, B          out  XLEN  ALU operands
//  illegal_op    out  1     op in output slot has no legal ALU encoding
// BEHAVIOUR
//  Encoding (fixed): AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, XOR 1100, SLL 1101,
//   SRL 1110, SRA 1000; illegal -> 1111 (ALU returns 0) with illegal_op=1.
//  Decode: class 00 -> ADD. class 01 -> SUB. class 10/11 by funct3:
//   000 ADD (class 10 and funct7_b5 -> SUB; ignored in class 11); 111 AND; 110 OR; 100 XOR;
//   010 SLT; 001 SLL; 101 SRL, or SRA if funct7_b5.
//  Illegal: funct3 011 (SLTU) in class 10/11; class 11 with funct3 001 and funct7_b5=1.
//  Operands: A = rs1_data; B = alu_src ? imm : rs2_data.
//   For SLL/SRL/SRA, B is zero-extended from B[4:0] (upper bits forced 0).
//  Handshake:
//   - Input transfer on in_valid & in_ready; output transfer on out_valid & out_ready.
//   - Latency 1 cycle when the buffer is empty.
//   - Registered fields must not change while out_valid & !out_ready.
//  Buffer: main slot drives outputs; skid slot is filled only when main is occupied, not consumed,
//   and an input transfer occurs. in_ready = !skid_full, registered (no comb path from out_ready).
//  Simultaneous in and out transfer with only main full: main reloads with the new op, no skid use.
//  When main is consumed and skid is full: skid moves to main the next cycle.
//  Order preserved; never more than 2 ops held.
//  Boundary cases:
//   - flush and rst both clear both slots; an input presented in the flush cycle is dropped.
//   - rst overrides flush.
//   - Reset values: out_valid=0, in_ready=1, AluOp=0000, A=0, B=0, illegal_op=0.
//   - Reset mid-transfer discards everything; no partial op is emitted.
// STRUCTURE
//  Shared package: AluOp localparams (ALU_AND..ALU_SRA, ALU_ILL) and ALUOp class constants,
//  shared with the ALU.
//  Sub-module alu_op_decode: purely combinational (class,funct3,funct7_b5) -> {AluOp, illegal, is_shift}.
//  Top level holds the operand mux and the 2-entry skid buffer.
// TESTING
//  1. rst held 2 cycles -> out_valid=0, in_ready=1, AluOp=0, A=B=0.
//  2. R-type funct3=000 funct7_b5=1, rs1=10, rs2=3, out_ready=1
//     -> next cycle AluOp=0110, A=10, B=3, out_valid=1.
//  3. I-type funct3=101 funct7_b5=1, imm=32'h0000_0423
//     -> AluOp=1000, B=32'h0000_0003.
//  4. out_ready=0 while 3 ops offered back-to-back
//     -> ops 1,2 accepted; in_ready=0 from the cycle after op 2; op 3 held upstream.
//     Release out_ready -> ops emerge in order 1,2,3, none lost or duplicated.
//  5. funct3=011 class 10 -> AluOp=1111, illegal_op=1.
//     Class 11 funct3=001 funct7_b5=1 -> illegal_op=1.
//  6. Buffer full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input absent.

Source files
------------

// File: rtl/alu_issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_pkg
//  Description : Shared ALU operation codes and ALUOp class constants used by
//                the ALU issue stage and the ALU itself.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_pkg;

  // 4-bit ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1101;
  localparam logic [3:0] ALU_SRL = 4'b1110;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_ILL = 4'b1111;  // ALU returns 0

  // ALUOp instruction classes
  localparam logic [1:0] CLS_MEM = 2'b00;  // load/store address add
  localparam logic [1:0] CLS_BR  = 2'b01;  // branch compare via subtract
  localparam logic [1:0] CLS_R   = 2'b10;  // register-register ALU
  localparam logic [1:0] CLS_I   = 2'b11;  // register-immediate ALU

  // funct3 values for the ALU classes
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Shift amount width: shifts only use the low operand bits
  localparam int unsigned SHAMT_W = 5;

endpackage
`default_nettype wire

// File: rtl/alu_issue_op_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_decode
//  Description : Combinational decode of (ALUOp class, funct3, funct7[5])
//                into the 4-bit ALU operation code.
//  Ports       : alu_op_class, funct3, funct7_b5 -> alu_op, illegal, is_shift
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
  import alu_issue_pkg::*;
(
  input  logic [1:0] alu_op_class,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic [3:0] alu_op,
  output logic       illegal,
  output logic       is_shift
);

  always_comb begin
    alu_op   = ALU_ADD;
    illegal  = 1'b0;
    is_shift = 1'b0;
    case (alu_op_class)
      CLS_MEM: alu_op = ALU_ADD;
      CLS_BR:  alu_op = ALU_SUB;
      default: begin
        case (funct3)
          // funct7[5] selects SUB only for register ops; in I-type it is imm bits
          F3_ADD:  alu_op = (alu_op_class == CLS_R && funct7_b5) ? ALU_SUB : ALU_ADD;
          F3_AND:  alu_op = ALU_AND;
          F3_OR:   alu_op = ALU_OR;
          F3_XOR:  alu_op = ALU_XOR;
          F3_SLT:  alu_op = ALU_SLT;
          F3_SLL: begin
            alu_op   = ALU_SLL;
            is_shift = 1'b1;
            // SLLI with imm[10] set has no encoding
            if (alu_op_class == CLS_I && funct7_b5) illegal = 1'b1;
          end
          F3_SR: begin
            alu_op   = funct7_b5 ? ALU_SRA : ALU_SRL;
            is_shift = 1'b1;
          end
          F3_SLTU: illegal = 1'b1;  // unsigned compare not provided by this ALU
          default: illegal = 1'b1;
        endcase
      end
    endcase
    if (illegal) begin
      alu_op   = ALU_ILL;
      is_shift = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue
//  Description : ALU issue stage. Decodes the ALU operation, selects operands
//                and holds up to two ops in a skid buffer toward the ALU.
//  Ports       : clk, rst, flush            - clock, sync reset, sync discard
//                in_valid/in_ready          - upstream handshake
//                alu_op_class, funct3, funct7_b5, alu_src,
//                rs1_data, rs2_data, imm    - op fields
//                out_valid/out_ready        - ALU-side handshake
//                AluOp, A, B, illegal_op    - registered op toward the ALU
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op_class,
  input  logic [2:0]      funct3,
  input  logic            funct7_b5,
  input  logic            alu_src,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      AluOp,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic            illegal_op
);

  logic [3:0]      in_op;
  logic            in_ill;
  logic            in_shift;
  logic [XLEN-1:0] b_src;
  logic [XLEN-1:0] in_b;

  alu_op_decode u_decode (
    .alu_op_class (alu_op_class),
    .funct3       (funct3),
    .funct7_b5    (funct7_b5),
    .alu_op       (in_op),
    .illegal      (in_ill),
    .is_shift     (in_shift)
  );

  // Operand B select; shifts only see the shift amount
  always_comb begin
    b_src = alu_src ? imm : rs2_data;
    in_b  = b_src;
    if (in_shift) in_b = {{(XLEN-SHAMT_W){1'b0}}, b_src[SHAMT_W-1:0]};
  end

  // Main slot drives the outputs; skid slot catches one op under backpressure
  logic            main_valid_q, main_valid_d;
  logic [3:0]      main_op_q,    main_op_d;
  logic            main_ill_q,   main_ill_d;
  logic [XLEN-1:0] main_a_q,     main_a_d;
  logic [XLEN-1:0] main_b_q,     main_b_d;
  logic            skid_valid_q, skid_valid_d;
  logic [3:0]      skid_op_q,    skid_op_d;
  logic            skid_ill_q,   skid_ill_d;
  logic [XLEN-1:0] skid_a_q,     skid_a_d;
  logic [XLEN-1:0] skid_b_q,     skid_b_d;

  logic in_xfer;
  logic out_xfer;

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally
  assign in_ready = !skid_valid_q;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_op_d    = main_op_q;
    main_ill_d   = main_ill_q;
    main_a_d     = main_a_q;
    main_b_d     = main_b_q;
    skid_valid_d = skid_valid_q;
    skid_op_d    = skid_op_q;
    skid_ill_d   = skid_ill_q;
    skid_a_d     = skid_a_q;
    skid_b_d     = skid_b_q;

    if (!main_valid_q || out_xfer) begin
      // Main slot is free next cycle: older skid op first, else the new input
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_op_d    = skid_op_q;
        main_ill_d   = skid_ill_q;
        main_a_d     = skid_a_q;
        main_b_d     = skid_b_q;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        main_valid_d = 1'b1;
        main_op_d    = in_op;
        main_ill_d   = in_ill;
        main_a_d     = rs1_data;
        main_b_d     = in_b;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      // Main stalled and holding: park the new op in the skid slot
      skid_valid_d = 1'b1;
      skid_op_d    = in_op;
      skid_ill_d   = in_ill;
      skid_a_d     = rs1_data;
      skid_b_d     = in_b;
    end

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_op_q    <= 4'b0000;
      main_ill_q   <= 1'b0;
      main_a_q     <= '0;
      main_b_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_op_q    <= 4'b0000;
      skid_ill_q   <= 1'b0;
      skid_a_q     <= '0;
      skid_b_q     <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_op_q    <= main_op_d;
      main_ill_q   <= main_ill_d;
      main_a_q     <= main_a_d;
      main_b_q     <= main_b_d;
      skid_valid_q <= skid_valid_d;
      skid_op_q    <= skid_op_d;
      skid_ill_q   <= skid_ill_d;
      skid_a_q     <= skid_a_d;
      skid_b_q     <= skid_b_d;
    end
  end

  assign out_valid  = main_valid_q;
  assign AluOp      = main_op_q;
  assign A          = main_a_q;
  assign B          = main_b_q;
  assign illegal_op = main_ill_q;

endmodule
`default_nettype wire
